dat_xfer_ctrl: RTL and testbench
================================

// Module: dat_xfer_ctrl
// PURPOSE
//  Parametrised DAT-line transfer sequencer: second-generation controller driving block reader/writer engine and data buffer.
//  Adds infinite (block-count-disabled) transfers, write busy wait on DAT0, write-busy timeout, abort, optional stop-at-block-gap.
//  Sits between register file, CMD path, buffer and DAT engines.
// PARAMETERS
//  CntWidth      16  width of block counter / block_count_i
//  TimeoutWidth  24  width of timeout limit and counter (units: sd_clk_en_p_i ticks)
// PORTS
//  clk_i             in   1             system clock; single clock domain
//  rst_i             in   1             synchronous, active-high reset
//  sd_clk_en_p_i     in   1             SD clock rising-edge enable strobe
//  abort_i           in   1             DAT software reset; sync return to IDLE
//  cmd_issued_i      in   1             command with data-present written (1-cycle)
//  dir_read_i        in   1             1=read (card->host), 0=write; sampled with cmd_issued_i
//  block_count_en_i  in   1             0 = infinite transfer
//  block_count_i     in   CntWidth      blocks to transfer; sampled with cmd_issued_i
//  auto_cmd12_en_i   in   1             request CMD12 at end of transfer
//  timeout_limit_i   in   TimeoutWidth  data/busy timeout, in sd_clk_en_p_i ticks
//  stop_at_gap_i     in   1             stop at next block gap (macro only)
//  continue_i        in   1             resume from gap, 1-cycle (macro only)
//  sd_cmd_done_i     in   1             read command sent
//  sd_rsp_done_i     in   1             write command response received
//  buf_wr_ready_i    in   1             buffer can accept one more block (read)
//  buf_rd_valid_i    in   1             buffer holds one full block (write)
//  buf_empty_i       in   1             buffer drained by host
//  eng_done_i        in   1             engine finished block (1-cycle)
//  eng_crc_err_i     in   1             valid with eng_done_i
//  eng_end_bit_err_i in   1             valid with eng_done_i
//  eng_busy_i        in   1             card holding DAT0 low after write
//  eng_start_o       out  1             start engine for one block
//  pause_sd_clk_o    out  1             stop SD clock (read-wait)
//  read_active_o     out  1             read transfer active
//  write_active_o    out  1             write transfer active
//  request_cmd12_o   out  1             1-cycle CMD12 request
//  xfer_complete_o   out  1             1-cycle transfer-complete pulse
//  block_gap_o       out  1             1-cycle block-gap-event pulse
//  crc_err_o / end_bit_err_o / timeout_err_o  out  1  1-cycle error pulses
//  blocks_left_o     out  CntWidth      remaining block counter
// BEHAVIOUR
//  - Reset/abort: state IDLE, counters 0; all outputs 0. abort_i beats every other input, any state.
//  - IDLE: on cmd_issued_i latch dir, count_en, blocks_left=block_count_i.
//    Read -> WAIT_CMD; write -> WAIT_RSP. count_en && block_count_i==0: command ignored.
//  - WAIT_CMD: sd_cmd_done_i -> WAIT_BUF. WAIT_RSP: sd_rsp_done_i -> WAIT_BUF.
//  - WAIT_BUF: read needs buf_wr_ready_i (pause_sd_clk_o=1 while waiting).
//    Write needs buf_rd_valid_i. Condition met -> START.
//  - START: eng_start_o=1 combinationally; leave to XFER on the cycle sd_clk_en_p_i=1.
//  - XFER: timeout counter cleared on entry, +1 per sd_clk_en_p_i. Read only: count==timeout_limit_i -> TIMEOUT.
//    eng_done_i -> BLOCK_DONE, pulsing crc_err_o/end_bit_err_o same cycle. done and timeout together: done wins.
//  - BLOCK_DONE (1 cycle): blocks_left -1 if count_en (no wrap; stays at 0).
//    last = count_en && blocks_left==1 before decrement.
//    Write -> WR_BUSY. Read: last -> DRAIN, gap -> GAP, else WAIT_BUF.
//  - WR_BUSY: counter cleared on entry, counts while eng_busy_i; limit -> TIMEOUT.
//    eng_busy_i==0 -> last ? DONE : gap ? GAP : WAIT_BUF.
//  - DRAIN: request_cmd12_o pulses once on entry if auto_cmd12_en_i; buf_empty_i -> DONE.
//  - DONE: xfer_complete_o=1; write with auto_cmd12_en_i also pulses request_cmd12_o; -> IDLE.
//  - TIMEOUT: timeout_err_o=1, no xfer_complete_o; -> IDLE.
//  - read_active_o=1 in WAIT_CMD..DRAIN/DONE/TIMEOUT of a read; write_active_o likewise for writes. Decoded from state.
//  - Infinite mode ends only via abort_i or a timeout.
// CONFIGURATION
//  SDHCI_STOP_AT_BLOCK_GAP_EN defined: stop_at_gap_i sampled in BLOCK_DONE (reads) and on WR_BUSY exit (writes).
//    Set and not last -> GAP; last beats gap.
//    GAP: block_gap_o on entry; read holds pause_sd_clk_o=1; continue_i -> WAIT_BUF.
//  Undefined: GAP state absent, stop_at_gap_i/continue_i ignored, block_gap_o tied 0.
// TESTING
//  - Read, count 3, auto CMD12: 3 eng_start_o; blocks_left 3->0; one request_cmd12_o in DRAIN; xfer_complete_o after buf_empty_i.
//  - Read, buf_wr_ready_i low 50 cycles after block 1: pause_sd_clk_o=1 for those 50 cycles, then block 2 starts.
//  - Write, count 2, eng_busy_i high 20 ticks: WR_BUSY 20 ticks each block; blocks_left 0; one xfer_complete_o.
//  - Read, timeout_limit_i=100, no eng_done_i: timeout_err_o at tick 100; back IDLE; no xfer_complete_o.
//  - Infinite write, abort_i after block 5: IDLE next cycle; all outputs 0; blocks_left_o=0.
//  - Macro on, read, count 4, stop_at_gap_i after block 2: block_gap_o; continue_i -> blocks 3,4 complete.

Source files
------------

// File: rtl/dat_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dat_xfer_ctrl                                                    |
// | Brief   : DAT-line block transfer sequencer (read/write, busy, timeout,    |
// |           abort). Optional stop-at-block-gap via SDHCI_STOP_AT_BLOCK_GAP_EN|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dat_xfer_ctrl #(
    parameter int CntWidth     = 16,
    parameter int TimeoutWidth = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sd_clk_en_p_i,
    input  logic                    abort_i,
    input  logic                    cmd_issued_i,
    input  logic                    dir_read_i,
    input  logic                    block_count_en_i,
    input  logic [CntWidth-1:0]     block_count_i,
    input  logic                    auto_cmd12_en_i,
    input  logic [TimeoutWidth-1:0] timeout_limit_i,
    input  logic                    stop_at_gap_i,
    input  logic                    continue_i,
    input  logic                    sd_cmd_done_i,
    input  logic                    sd_rsp_done_i,
    input  logic                    buf_wr_ready_i,
    input  logic                    buf_rd_valid_i,
    input  logic                    buf_empty_i,
    input  logic                    eng_done_i,
    input  logic                    eng_crc_err_i,
    input  logic                    eng_end_bit_err_i,
    input  logic                    eng_busy_i,
    output logic                    eng_start_o,
    output logic                    pause_sd_clk_o,
    output logic                    read_active_o,
    output logic                    write_active_o,
    output logic                    request_cmd12_o,
    output logic                    xfer_complete_o,
    output logic                    block_gap_o,
    output logic                    crc_err_o,
    output logic                    end_bit_err_o,
    output logic                    timeout_err_o,
    output logic [CntWidth-1:0]     blocks_left_o
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WAIT_CMD   = 4'd1;
    localparam logic [3:0] S_WAIT_RSP   = 4'd2;
    localparam logic [3:0] S_WAIT_BUF   = 4'd3;
    localparam logic [3:0] S_START      = 4'd4;
    localparam logic [3:0] S_XFER       = 4'd5;
    localparam logic [3:0] S_BLOCK_DONE = 4'd6;
    localparam logic [3:0] S_WR_BUSY    = 4'd7;
    localparam logic [3:0] S_DRAIN      = 4'd8;
    localparam logic [3:0] S_DONE       = 4'd9;
    localparam logic [3:0] S_TIMEOUT    = 4'd10;
`ifdef SDHCI_STOP_AT_BLOCK_GAP_EN
    localparam logic [3:0] S_GAP        = 4'd11;
    localparam logic [3:0] S_GAP_TGT    = S_GAP;
`else
    localparam logic [3:0] S_GAP_TGT    = S_WAIT_BUF;
`endif

    logic [3:0]              r_state;
    logic [3:0]              w_state_next;
    logic                    r_dir_read;
    logic                    r_cnt_en;
    logic                    r_last;
    logic                    r_first;
    logic [CntWidth-1:0]     r_blocks_left;
    logic [TimeoutWidth-1:0] r_tcnt;
    logic                    w_cmd_accept;
    logic                    w_last_now;
    logic                    w_tout_hit;
    logic                    w_gap_req;
    logic                    w_in_gap;

    assign w_cmd_accept = cmd_issued_i && !(block_count_en_i && (block_count_i == '0));
    assign w_last_now   = r_cnt_en && (r_blocks_left == CntWidth'(1));
    assign w_tout_hit   = (r_tcnt == timeout_limit_i);

`ifdef SDHCI_STOP_AT_BLOCK_GAP_EN
    assign w_gap_req = stop_at_gap_i;
    assign w_in_gap  = (r_state == S_GAP);
`else
    // Gap controls have no effect in this build.
    logic w_unused_gap;
    assign w_unused_gap = stop_at_gap_i ^ continue_i;
    assign w_gap_req    = 1'b0;
    assign w_in_gap     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:       if (w_cmd_accept) w_state_next = dir_read_i ? S_WAIT_CMD : S_WAIT_RSP;
                S_WAIT_CMD:   if (sd_cmd_done_i) w_state_next = S_WAIT_BUF;
                S_WAIT_RSP:   if (sd_rsp_done_i) w_state_next = S_WAIT_BUF;
                S_WAIT_BUF:   if (r_dir_read ? buf_wr_ready_i : buf_rd_valid_i) w_state_next = S_START;
                S_START:      if (sd_clk_en_p_i) w_state_next = S_XFER;
                S_XFER: begin
                    if (eng_done_i)                    w_state_next = S_BLOCK_DONE;
                    else if (r_dir_read && w_tout_hit) w_state_next = S_TIMEOUT;
                end
                S_BLOCK_DONE: begin
                    if (!r_dir_read)    w_state_next = S_WR_BUSY;
                    else if (w_last_now) w_state_next = S_DRAIN;
                    else if (w_gap_req)  w_state_next = S_GAP_TGT;
                    else                 w_state_next = S_WAIT_BUF;
                end
                S_WR_BUSY: begin
                    if (!eng_busy_i)     w_state_next = r_last ? S_DONE : (w_gap_req ? S_GAP_TGT : S_WAIT_BUF);
                    else if (w_tout_hit) w_state_next = S_TIMEOUT;
                end
                S_DRAIN:      if (buf_empty_i) w_state_next = S_DONE;
                S_DONE:       w_state_next = S_IDLE;
                S_TIMEOUT:    w_state_next = S_IDLE;
`ifdef SDHCI_STOP_AT_BLOCK_GAP_EN
                S_GAP:        if (continue_i) w_state_next = S_WAIT_BUF;
`endif
                default:      w_state_next = S_IDLE;
            endcase
        end
    end

    // Timeout counter restarts on every state change, so it is clear on entry to XFER/WR_BUSY.
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            r_dir_read    <= 1'b0;
            r_cnt_en      <= 1'b0;
            r_last        <= 1'b0;
            r_first       <= 1'b0;
            r_blocks_left <= '0;
            r_tcnt        <= '0;
        end else begin
            r_first <= (w_state_next != r_state);
            if ((r_state == S_IDLE) && w_cmd_accept) begin
                r_dir_read    <= dir_read_i;
                r_cnt_en      <= block_count_en_i;
                r_blocks_left <= block_count_i;
            end
            if (r_state == S_BLOCK_DONE) begin
                r_last <= w_last_now;
                if (r_cnt_en && (r_blocks_left != '0)) begin
                    r_blocks_left <= r_blocks_left - CntWidth'(1);
                end
            end
            if (w_state_next != r_state) begin
                r_tcnt <= '0;
            end else if (sd_clk_en_p_i && ((r_state == S_XFER) || ((r_state == S_WR_BUSY) && eng_busy_i))) begin
                r_tcnt <= r_tcnt + TimeoutWidth'(1);
            end
        end
    end

    always_comb begin
        eng_start_o     = (r_state == S_START);
        pause_sd_clk_o  = r_dir_read && (((r_state == S_WAIT_BUF) && !buf_wr_ready_i) || w_in_gap);
        read_active_o   = r_dir_read && (r_state != S_IDLE);
        write_active_o  = !r_dir_read && (r_state != S_IDLE);
        request_cmd12_o = auto_cmd12_en_i &&
                          (((r_state == S_DRAIN) && r_first) || ((r_state == S_DONE) && !r_dir_read));
        xfer_complete_o = (r_state == S_DONE);
        block_gap_o     = w_in_gap && r_first;
        crc_err_o       = (r_state == S_XFER) && eng_done_i && eng_crc_err_i;
        end_bit_err_o   = (r_state == S_XFER) && eng_done_i && eng_end_bit_err_i;
        timeout_err_o   = (r_state == S_TIMEOUT);
        blocks_left_o   = r_blocks_left;
    end

endmodule
`default_nettype wire

// File: tb/tb_dat_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dat_xfer_ctrl                                                 |
// | Brief   : Directed self-checking bench for dat_xfer_ctrl                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dat_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        sd_clk_en_p_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        cmd_issued_i = 1'b0;
    logic        dir_read_i = 1'b0;
    logic        block_count_en_i = 1'b0;
    logic [15:0] block_count_i = '0;
    logic        auto_cmd12_en_i = 1'b0;
    logic [23:0] timeout_limit_i = 24'd1000;
    logic        stop_at_gap_i = 1'b0;
    logic        continue_i = 1'b0;
    logic        sd_cmd_done_i = 1'b0;
    logic        sd_rsp_done_i = 1'b0;
    logic        buf_wr_ready_i = 1'b1;
    logic        buf_rd_valid_i = 1'b1;
    logic        buf_empty_i = 1'b1;
    logic        eng_done_i = 1'b0;
    logic        eng_crc_err_i = 1'b0;
    logic        eng_end_bit_err_i = 1'b0;
    logic        eng_busy_i = 1'b0;
    logic        eng_start_o, pause_sd_clk_o, read_active_o, write_active_o;
    logic        request_cmd12_o, xfer_complete_o, block_gap_o;
    logic        crc_err_o, end_bit_err_o, timeout_err_o;
    logic [15:0] blocks_left_o;

    dat_xfer_ctrl #(.CntWidth(16), .TimeoutWidth(24)) dut (
        .clk_i(clk), .rst_i(rst_i), .sd_clk_en_p_i(sd_clk_en_p_i), .abort_i(abort_i),
        .cmd_issued_i(cmd_issued_i), .dir_read_i(dir_read_i), .block_count_en_i(block_count_en_i),
        .block_count_i(block_count_i), .auto_cmd12_en_i(auto_cmd12_en_i),
        .timeout_limit_i(timeout_limit_i), .stop_at_gap_i(stop_at_gap_i), .continue_i(continue_i),
        .sd_cmd_done_i(sd_cmd_done_i), .sd_rsp_done_i(sd_rsp_done_i),
        .buf_wr_ready_i(buf_wr_ready_i), .buf_rd_valid_i(buf_rd_valid_i), .buf_empty_i(buf_empty_i),
        .eng_done_i(eng_done_i), .eng_crc_err_i(eng_crc_err_i), .eng_end_bit_err_i(eng_end_bit_err_i),
        .eng_busy_i(eng_busy_i), .eng_start_o(eng_start_o), .pause_sd_clk_o(pause_sd_clk_o),
        .read_active_o(read_active_o), .write_active_o(write_active_o),
        .request_cmd12_o(request_cmd12_o), .xfer_complete_o(xfer_complete_o),
        .block_gap_o(block_gap_o), .crc_err_o(crc_err_o), .end_bit_err_o(end_bit_err_o),
        .timeout_err_o(timeout_err_o), .blocks_left_o(blocks_left_o)
    );

    always #5 clk = ~clk;

    // SD clock enable: one tick every second system clock.
    initial forever begin
        @(posedge clk);
        #1 sd_clk_en_p_i = ~sd_clk_en_p_i;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Event counters and reference model state.
    int   n_start, n_cmd12, n_cmp, n_gap, n_tout, n_crc, n_ebe, n_pause, n_both, n_tick;
    bit   start_d, seen_start, mon_en;
    int   m_left = 0;
    bit   m_en = 0, m_dir = 0, dec_pend = 0;

    task automatic clear_cnt();
        n_start = 0; n_cmd12 = 0; n_cmp = 0; n_gap = 0; n_tout = 0;
        n_crc = 0; n_ebe = 0; n_pause = 0; n_both = 0; n_tick = 0; seen_start = 0;
    endtask

    initial begin
        clear_cnt();
        start_d = 0;
        mon_en  = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("blocks_left", blocks_left_o, m_left);
                chk("rd_wr_excl", read_active_o && write_active_o, 0);
                if (read_active_o || write_active_o) chk("direction", read_active_o, m_dir);
                chk("start_idle", eng_start_o && !(read_active_o || write_active_o), 0);
                chk("pause_write", pause_sd_clk_o && !read_active_o, 0);
                chk("crc_pulse", crc_err_o, eng_done_i && eng_crc_err_i);
                chk("ebe_pulse", end_bit_err_o, eng_done_i && eng_end_bit_err_i);
                chk("cmp_and_tout", xfer_complete_o && timeout_err_o, 0);
            end
            if (eng_start_o && !start_d) n_start++;
            start_d = eng_start_o;
            if (eng_start_o) seen_start = 1;
            if (seen_start && sd_clk_en_p_i && read_active_o && !eng_start_o && !timeout_err_o) n_tick++;
            n_cmd12 += int'(request_cmd12_o);
            n_cmp   += int'(xfer_complete_o);
            n_gap   += int'(block_gap_o);
            n_tout  += int'(timeout_err_o);
            n_crc   += int'(crc_err_o);
            n_ebe   += int'(end_bit_err_o);
            n_pause += int'(pause_sd_clk_o);
            n_both  += int'(request_cmd12_o && xfer_complete_o);
            // Model: each finished block decrements the count, visible two cycles on.
            if (dec_pend) begin
                if (m_en && m_left != 0) m_left--;
                dec_pend = 0;
            end
            if (eng_done_i) dec_pend = 1;
            if (cmd_issued_i && !(block_count_en_i && block_count_i == 0)) begin
                m_left = int'(block_count_i);
                m_en   = block_count_en_i;
                m_dir  = dir_read_i;
            end
            if (abort_i || rst_i) begin
                m_left = 0;
                dec_pend = 0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rd, input bit en, input int cnt);
        cycles(1);
        dir_read_i = rd; block_count_en_i = en; block_count_i = 16'(cnt); cmd_issued_i = 1;
        cycles(1);
        cmd_issued_i = 0;
        cycles(2);
        if (rd) sd_cmd_done_i = 1; else sd_rsp_done_i = 1;
        cycles(1);
        sd_cmd_done_i = 0; sd_rsp_done_i = 0;
    endtask

    task automatic do_block(input bit crc, input bit ebe, input int busy_cyc);
        int n = 0;
        while (!eng_start_o && n < 400) begin @(negedge clk); n++; end
        chk("start_wait", eng_start_o, 1);
        n = 0;
        while (eng_start_o && n < 50) begin @(negedge clk); n++; end
        chk("start_leave", eng_start_o, 0);
        cycles(3);
        eng_done_i = 1; eng_crc_err_i = crc; eng_end_bit_err_i = ebe;
        cycles(1);
        eng_done_i = 0; eng_crc_err_i = 0; eng_end_bit_err_i = 0;
        if (busy_cyc > 0) begin
            eng_busy_i = 1;
            cycles(busy_cyc);
            chk("busy_hold_active", write_active_o, 1);
            chk("busy_no_cmp", n_cmp, 0);
            eng_busy_i = 0;
        end
    endtask

    task automatic wait_cmp();
        int n = 0;
        while (n_cmp == 0 && n < 400) begin @(negedge clk); n++; end
        chk("cmp_wait", n_cmp, 1);
    endtask

    initial begin
        cycles(3);
        rst_i = 0;
        @(negedge clk);
        chk("rst_active", {read_active_o, write_active_o, eng_start_o, pause_sd_clk_o}, 0);
        chk("rst_pulses", {request_cmd12_o, xfer_complete_o, block_gap_o, timeout_err_o}, 0);
        chk("rst_left", blocks_left_o, 0);
        mon_en = 1;

        // Read x3 with auto CMD12; drain held until buffer empties.
        clear_cnt();
        auto_cmd12_en_i = 1; buf_empty_i = 0;
        issue(1, 1, 3);
        for (int b = 0; b < 3; b++) do_block(0, 0, 0);
        cycles(10);
        chk("r3_cmd12_drain", n_cmd12, 1);
        chk("r3_no_cmp_yet", n_cmp, 0);
        chk("r3_active_drain", read_active_o, 1);
        buf_empty_i = 1;
        wait_cmp();
        @(negedge clk);
        chk("r3_starts", n_start, 3);
        chk("r3_left", blocks_left_o, 0);
        chk("r3_cmd12_total", n_cmd12, 1);
        chk("r3_idle", read_active_o, 0);

        // Read x2, buffer full 50 cycles after block 1; error flags on each block.
        clear_cnt();
        auto_cmd12_en_i = 0;
        issue(1, 1, 2);
        do_block(1, 0, 0);
        buf_wr_ready_i = 0;
        cycles(51);
        buf_wr_ready_i = 1;
        do_block(0, 1, 0);
        wait_cmp();
        chk("r2_pause_cycles", n_pause, 50);
        chk("r2_starts", n_start, 2);
        chk("r2_crc", n_crc, 1);
        chk("r2_ebe", n_ebe, 1);
        chk("r2_no_cmd12", n_cmd12, 0);

        // Write x2, busy 40 cycles (20 ticks) per block, auto CMD12 in DONE.
        clear_cnt();
        auto_cmd12_en_i = 1;
        issue(0, 1, 2);
        do_block(0, 0, 40);
        do_block(0, 0, 40);
        wait_cmp();
        @(negedge clk);
        chk("w2_starts", n_start, 2);
        chk("w2_left", blocks_left_o, 0);
        chk("w2_cmd12_with_cmp", n_both, 1);
        chk("w2_idle", write_active_o, 0);
        auto_cmd12_en_i = 0;

        // Read timeout: limit 100 ticks, engine never finishes.
        clear_cnt();
        timeout_limit_i = 24'd100;
        issue(1, 1, 1);
        begin
            int n = 0;
            while (n_tout == 0 && n < 600) begin @(negedge clk); n++; end
        end
        chk("to_pulse", n_tout, 1);
        chk("to_ticks", n_tick, 100);
        @(negedge clk);
        chk("to_no_cmp", n_cmp, 0);
        chk("to_idle", read_active_o, 0);
        timeout_limit_i = 24'd1000;

        // Infinite write aborted once the sixth block starts.
        clear_cnt();
        issue(0, 0, 7);
        for (int b = 0; b < 5; b++) do_block(0, 0, 4);
        begin
            int n = 0;
            while (!eng_start_o && n < 100) begin @(negedge clk); n++; end
        end
        cycles(1);
        abort_i = 1;
        cycles(1);
        abort_i = 0;
        @(negedge clk);
        chk("ab_starts", n_start, 6);
        chk("ab_active", {read_active_o, write_active_o, eng_start_o, pause_sd_clk_o}, 0);
        chk("ab_left", blocks_left_o, 0);
        chk("ab_no_cmp", n_cmp, 0);

        // Counted command with zero blocks is ignored.
        clear_cnt();
        cycles(1);
        dir_read_i = 1; block_count_en_i = 1; block_count_i = 0; cmd_issued_i = 1;
        cycles(1);
        cmd_issued_i = 0;
        cycles(5);
        chk("zero_cnt_ignored", {read_active_o, write_active_o}, 0);

`ifdef SDHCI_STOP_AT_BLOCK_GAP_EN
        // Read x4 stopping at the gap after block 2.
        clear_cnt();
        issue(1, 1, 4);
        do_block(0, 0, 0);
        stop_at_gap_i = 1;
        do_block(0, 0, 0);
        cycles(1);
        stop_at_gap_i = 0;
        cycles(10);
        @(negedge clk);
        chk("gap_pulse", n_gap, 1);
        chk("gap_pause", pause_sd_clk_o, 1);
        chk("gap_starts", n_start, 2);
        cycles(1);
        continue_i = 1;
        cycles(1);
        continue_i = 0;
        do_block(0, 0, 0);
        do_block(0, 0, 0);
        wait_cmp();
        chk("gap_starts_all", n_start, 4);
`else
        // Gap request has no effect in this build.
        clear_cnt();
        stop_at_gap_i = 1;
        issue(1, 1, 2);
        do_block(0, 0, 0);
        do_block(0, 0, 0);
        wait_cmp();
        stop_at_gap_i = 0;
        chk("nogap_pulse", n_gap, 0);
        chk("nogap_starts", n_start, 2);
`endif
        @(negedge clk);
        chk("final_left", blocks_left_o, 0);
        cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
